// File: rtl/sccomp_pkg.sv
// Shared definitions for the single-cycle MIPS-subset computer: ISA encodings,
// datapath select enums and the decoded control word.
package sccomp_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [XLEN-1:0]   RESET_PC = '0;
    localparam logic [REG_AW-1:0] LINK_REG = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef enum logic [1:0] {NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_JR} npc_sel_e;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_e;
    typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_sel_e;

    typedef struct packed {
        logic     reg_we;
        logic     mem_we;
        logic     alu_src_imm;
        logic     alu_src_shamt;
        logic     zero_ext;
        logic     branch_ne;
        alu_op_e  alu_op;
        npc_sel_e npc_sel;
        wb_sel_e  wb_sel;
        dst_sel_e dst_sel;
    } ctrl_t;

    // Decoding of anything unrecognised collapses to this: no writes, PC+4.
    localparam ctrl_t CTRL_NOP = '{
        reg_we: 1'b0, mem_we: 1'b0, alu_src_imm: 1'b0, alu_src_shamt: 1'b0,
        zero_ext: 1'b0, branch_ne: 1'b0, alu_op: ALU_ADD, npc_sel: NPC_SEQ,
        wb_sel: WB_ALU, dst_sel: DST_RD
    };

    function automatic ctrl_t imm_alu(input alu_op_e op, input logic zext);
        ctrl_t c;
        c             = CTRL_NOP;
        c.reg_we      = 1'b1;
        c.alu_src_imm = 1'b1;
        c.zero_ext    = zext;
        c.alu_op      = op;
        c.dst_sel     = DST_RT;
        return c;
    endfunction

endpackage

// File: rtl/ctrl.sv
// Purely combinational instruction decoder producing the core's control word.
module ctrl
    import sccomp_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctl
);

    always_comb begin
        // NOTE: ctl gets a complete default before the case so no path can infer a latch.
        ctl = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                ctl.reg_we = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: ctl.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: ctl.alu_op = ALU_SUB;
                    FN_AND:  ctl.alu_op = ALU_AND;
                    FN_OR:   ctl.alu_op = ALU_OR;
                    FN_XOR:  ctl.alu_op = ALU_XOR;
                    FN_NOR:  ctl.alu_op = ALU_NOR;
                    FN_SLT:  ctl.alu_op = ALU_SLT;
                    FN_SLTU: ctl.alu_op = ALU_SLTU;
                    FN_SLL: begin ctl.alu_op = ALU_SLL; ctl.alu_src_shamt = 1'b1; end
                    FN_SRL: begin ctl.alu_op = ALU_SRL; ctl.alu_src_shamt = 1'b1; end
                    FN_SRA: begin ctl.alu_op = ALU_SRA; ctl.alu_src_shamt = 1'b1; end
                    FN_JR:  begin ctl.reg_we = 1'b0; ctl.npc_sel = NPC_JR; end
                    default: ctl.reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: ctl = imm_alu(ALU_ADD, 1'b0);
            OP_SLTI:  ctl = imm_alu(ALU_SLT, 1'b0);
            OP_SLTIU: ctl = imm_alu(ALU_SLTU, 1'b0);
            OP_ANDI:  ctl = imm_alu(ALU_AND, 1'b1);
            OP_ORI:   ctl = imm_alu(ALU_OR, 1'b1);
            OP_XORI:  ctl = imm_alu(ALU_XOR, 1'b1);
            OP_LUI:   ctl = imm_alu(ALU_LUI, 1'b1);
            OP_LW: begin
                ctl        = imm_alu(ALU_ADD, 1'b0);
                ctl.wb_sel = WB_MEM;
            end
            OP_SW: begin
                ctl.mem_we      = 1'b1;
                ctl.alu_src_imm = 1'b1;
            end
            OP_BEQ: ctl.npc_sel = NPC_BRANCH;
            OP_BNE: begin
                ctl.npc_sel   = NPC_BRANCH;
                ctl.branch_ne = 1'b1;
            end
            OP_J:   ctl.npc_sel = NPC_JUMP;
            OP_JAL: begin
                ctl.npc_sel = NPC_JUMP;
                ctl.reg_we  = 1'b1;
                ctl.dst_sel = DST_RA;
                ctl.wb_sel  = WB_LINK;
            end
            default: ctl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/dm.sv
// Word-addressed data RAM: combinational read, write on the rising edge.
module dm
    import sccomp_pkg::*;
#(
    parameter int DM_DEPTH = 128
) (
    input  logic            clk,
    input  logic            we,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    localparam int AW = $clog2(DM_DEPTH);

    logic [XLEN-1:0] ram [0:DM_DEPTH-1];
    logic [AW-1:0]   idx;
    logic            unused_addr_bits;

    assign idx              = addr[AW+1:2];
    assign unused_addr_bits = ^{addr[XLEN-1:AW+2], addr[1:0]};

    // NOTE: RAM contents have no reset; only the register file is cleared, and
    // leaving the array reset-free lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) ram[idx] <= wdata;
    end

    assign rdata = ram[idx];

endmodule

// File: rtl/im.sv
// Instruction ROM, preloaded externally; read combinationally by word index.
module im
    import sccomp_pkg::*;
#(
    parameter int IM_DEPTH = 128
) (
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    localparam int AW = $clog2(IM_DEPTH);

    logic [XLEN-1:0] ROM [0:IM_DEPTH-1];
    logic            unused_pc_bits;

    assign instr          = ROM[pc[AW+1:2]];
    assign unused_pc_bits = ^{pc[XLEN-1:AW+2], pc[1:0]};

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports, one write port and a
// debug read port. Register 0 is hardwired to zero on every read path.
module regfile
    import sccomp_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [XLEN-1:0]   wd,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [XLEN-1:0]   rd1,
    output logic [XLEN-1:0]   rd2,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [XLEN-1:0]   dbg_data
);

    logic [XLEN-1:0] rf [NUM_REGS-1:0];

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (we && wa != '0) begin
            rf[wa] <= wd;
        end
    end

    assign rd1      = (ra1 == '0) ? '0 : rf[ra1];
    assign rd2      = (ra2 == '0) ? '0 : rf[ra2];
    assign dbg_data = (rstn || dbg_sel == '0) ? '0 : rf[dbg_sel];

endmodule

// File: rtl/sccpu.sv
// Single-cycle core: decode, register read, ALU, write-back and next-PC
// selection all complete within one clock; PC is the only core-level flop.
module sccpu
    import sccomp_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [XLEN-1:0]   instr,
    output logic [XLEN-1:0]   PC,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_we,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic [REG_AW-1:0] reg_sel,
    output logic [XLEN-1:0]   reg_data
);

    ctrl_t             ctl;
    logic [REG_AW-1:0] rs_idx, rt_idx, rd_idx, shamt, wa;
    logic [XLEN-1:0]   rs_val, rt_val, imm_ext, alu_a, alu_b, alu_y, wb_data;
    logic [XLEN-1:0]   pc_plus4, br_target, jmp_target, next_pc;
    logic              rf_we, br_taken;

    assign rs_idx = instr[25:21];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign shamt  = instr[10:6];

    ctrl U_CTRL (.op(instr[31:26]), .funct(instr[5:0]), .ctl(ctl));

    // A reset edge must not let the aborted instruction commit anything.
    assign rf_we  = ctl.reg_we & ~rstn;
    assign mem_we = ctl.mem_we & ~rstn;

    regfile U_RF (
        .clk(clk), .rstn(rstn), .we(rf_we), .wa(wa), .wd(wb_data),
        .ra1(rs_idx), .ra2(rt_idx), .rd1(rs_val), .rd2(rt_val),
        .dbg_sel(reg_sel), .dbg_data(reg_data)
    );

    assign imm_ext = ctl.zero_ext ? {16'h0, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign alu_a   = ctl.alu_src_shamt ? {{(XLEN-REG_AW){1'b0}}, shamt} : rs_val;
    assign alu_b   = ctl.alu_src_imm ? imm_ext : rt_val;

    always_comb begin
        case (ctl.alu_op)
            ALU_ADD:  alu_y = alu_a + alu_b;
            ALU_SUB:  alu_y = alu_a - alu_b;
            ALU_AND:  alu_y = alu_a & alu_b;
            ALU_OR:   alu_y = alu_a | alu_b;
            ALU_XOR:  alu_y = alu_a ^ alu_b;
            ALU_NOR:  alu_y = ~(alu_a | alu_b);
            ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            ALU_SLL:  alu_y = alu_b << alu_a[4:0];
            ALU_SRL:  alu_y = alu_b >> alu_a[4:0];
            ALU_SRA:  alu_y = $unsigned($signed(alu_b) >>> alu_a[4:0]);
            ALU_LUI:  alu_y = {alu_b[15:0], 16'h0};
            default:  alu_y = '0;
        endcase
    end

    assign mem_addr  = alu_y;
    assign mem_wdata = rt_val;

    always_comb begin
        case (ctl.wb_sel)
            WB_MEM:  wb_data = mem_rdata;
            WB_LINK: wb_data = pc_plus4;
            default: wb_data = alu_y;
        endcase
        case (ctl.dst_sel)
            DST_RT:  wa = rt_idx;
            DST_RA:  wa = LINK_REG;
            default: wa = rd_idx;
        endcase
    end

    assign pc_plus4   = PC + 32'd4;
    assign br_target  = pc_plus4 + {imm_ext[XLEN-3:0], 2'b00};
    assign jmp_target = {pc_plus4[XLEN-1:XLEN-4], instr[25:0], 2'b00};
    assign br_taken   = (rs_val == rt_val) ^ ctl.branch_ne;

    always_comb begin
        case (ctl.npc_sel)
            NPC_BRANCH: next_pc = br_taken ? br_target : pc_plus4;
            NPC_JUMP:   next_pc = jmp_target;
            NPC_JR:     next_pc = rs_val;
            default:    next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so PC, register file and RAM all commit from pre-edge values.
        if (rstn) PC <= RESET_PC;
        else      PC <= next_pc;
    end

endmodule

// File: rtl/sccomp.sv
// Top of the single-cycle computer: core, instruction ROM and data RAM, with a
// combinational debug view of the register file.
module sccomp
    import sccomp_pkg::*;
#(
    parameter int IM_DEPTH = 128,
    parameter int DM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REG_AW-1:0] reg_sel,
    output logic [XLEN-1:0]   reg_data
);

    logic [XLEN-1:0] PC, instr, mem_addr, mem_wdata, mem_rdata;
    logic            mem_we;

    sccpu U_SCPU (
        .clk(clk), .rstn(rstn), .instr(instr), .PC(PC),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .reg_sel(reg_sel), .reg_data(reg_data)
    );

    im #(.IM_DEPTH(IM_DEPTH)) U_IM (.pc(PC), .instr(instr));

    dm #(.DM_DEPTH(DM_DEPTH)) U_DM (
        .clk(clk), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_sccomp.sv
// Bench for sccomp: directed program with hand-derived results, then random
// programs checked against an instruction-level reference model.
module tb_sccomp;

    logic        clk;
    logic        rstn;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prog [128];
    logic [31:0] m_rf [32];
    logic [31:0] m_dm [128];
    logic [31:0] m_pc;

    localparam logic [5:0] FUNCTS [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                          6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
    localparam logic [5:0] IOPS [8] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    sccomp #(.IM_DEPTH(128), .DM_DEPTH(128)) dut (
        .clk(clk), .rstn(rstn), .reg_sel(reg_sel), .reg_data(reg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = prog[i];
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm, off;
        logic [31:0] r;
        int          k;
        rs  = 5'($urandom_range(0, 31));
        rt  = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        sh  = 5'($urandom_range(0, 31));
        r   = $urandom;
        imm = r[15:0];
        off = 16'($urandom_range(0, 31));
        k   = $urandom_range(0, 21);
        if (k <= 6)       return enc_r(FUNCTS[$urandom_range(0, 12)], rs, rt, rd, sh);
        else if (k <= 13) return enc_i(IOPS[$urandom_range(0, 7)], rs, rt, imm);
        else if (k == 14) return enc_i(6'h23, 5'd0, rt, off);
        else if (k == 15) return enc_i(6'h2B, 5'd0, rt, off);
        else if (k <= 17) return enc_i((k == 16) ? 6'h04 : 6'h05, rs, rt,
                                       16'($urandom_range(0, 15)) - 16'd8);
        else if (k <= 19) return enc_j((k == 18) ? 6'h02 : 6'h03, r[25:0]);
        else if (k == 20) return enc_r(6'h08, rs, 5'd0, 5'd0, 5'd0);
        else              return ($urandom_range(0, 1) == 0) ? {6'h3F, r[25:0]}
                                                            : enc_r(6'h3F, rs, rt, rd, sh);
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    endtask

    // Executes one instruction straight from the ISA definition.
    task automatic model_step();
        logic [31:0] ins, a, b, sx, zx, res, npc, addr;
        logic [5:0]  op, fn;
        logic [4:0]  dst, sh;
        logic        wr;
        ins  = prog[m_pc[8:2]];
        op   = ins[31:26];
        fn   = ins[5:0];
        sh   = ins[10:6];
        a    = m_rf[ins[25:21]];
        b    = m_rf[ins[20:16]];
        sx   = {{16{ins[15]}}, ins[15:0]};
        zx   = {16'h0, ins[15:0]};
        addr = a + sx;
        npc  = m_pc + 32'd4;
        wr   = 1'b1;
        dst  = ins[20:16];
        res  = 32'h0;
        case (op)
            6'h00: begin
                dst = ins[15:11];
                case (fn)
                    6'h20, 6'h21: res = a + b;
                    6'h22, 6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    6'h03: res = $signed(b) >>> sh;
                    6'h08: begin wr = 1'b0; npc = a; end
                    default: wr = 1'b0;
                endcase
            end
            6'h08, 6'h09: res = a + sx;
            6'h0A: res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
            6'h0B: res = (a < sx) ? 32'd1 : 32'd0;
            6'h0C: res = a & zx;
            6'h0D: res = a | zx;
            6'h0E: res = a ^ zx;
            6'h0F: res = {ins[15:0], 16'h0};
            6'h23: res = m_dm[addr[8:2]];
            6'h2B: begin wr = 1'b0; m_dm[addr[8:2]] = b; end
            6'h04: begin wr = 1'b0; if (a == b) npc = m_pc + 32'd4 + (sx << 2); end
            6'h05: begin wr = 1'b0; if (a != b) npc = m_pc + 32'd4 + (sx << 2); end
            6'h02: begin wr = 1'b0; npc = {npc[31:28], ins[25:0], 2'b00}; end
            6'h03: begin dst = 5'd31; res = m_pc + 32'd4; npc = {npc[31:28], ins[25:0], 2'b00}; end
            default: wr = 1'b0;
        endcase
        if (wr && dst != 5'd0) m_rf[dst] = res;
        m_pc = npc;
    endtask

    initial begin
        logic [31:0] any_set;
        int          budget;
        rstn    = 1'b1;
        reg_sel = 5'd0;

        // ---------------- directed program ----------------
        for (int i = 0; i < 128; i++) prog[i] = 32'h0;
        prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);       // addi  $1,$0,5
        prog[1]  = enc_i(6'h0A, 5'd1, 5'd2, 16'd7);       // slti  $2,$1,7
        prog[2]  = enc_i(6'h0A, 5'd1, 5'd3, 16'd5);       // slti  $3,$1,5
        prog[3]  = enc_i(6'h0A, 5'd1, 5'd4, 16'hFFFF);    // slti  $4,$1,-1
        prog[4]  = enc_i(6'h08, 5'd0, 5'd5, 16'hFFFD);    // addi  $5,$0,-3
        prog[5]  = enc_i(6'h0A, 5'd5, 5'd6, 16'hFFFE);    // slti  $6,$5,-2
        prog[6]  = enc_i(6'h0B, 5'd5, 5'd7, 16'd1);       // sltiu $7,$5,1
        prog[7]  = enc_i(6'h0F, 5'd0, 5'd8, 16'h1234);    // lui   $8,0x1234
        prog[8]  = enc_i(6'h0D, 5'd8, 5'd8, 16'h5678);    // ori   $8,$8,0x5678
        prog[9]  = enc_i(6'h2B, 5'd0, 5'd8, 16'd4);       // sw    $8,4($0)
        prog[10] = enc_i(6'h23, 5'd0, 5'd9, 16'd4);       // lw    $9,4($0)
        prog[11] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);       // beq   $0,$0,+1
        prog[12] = enc_i(6'h08, 5'd0, 5'd10, 16'd99);     // addi  $10,$0,99 (skipped)
        prog[13] = enc_j(6'h03, 26'h12);                  // jal   0x12
        prog[18] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);       // addi  $0,$0,7
        prog[19] = enc_r(6'h20, 5'd1, 5'd5, 5'd12, 5'd0); // add   $12,$1,$5
        prog[20] = enc_j(6'h02, 26'd20);                  // j     self
        load_rom();

        tick();
        tick();
        check("reset_pc", dut.PC, 32'h0);
        reg_sel = 5'd1;
        #1;
        check("reset_reg_data", reg_data, 32'h0);
        check("reset_instr", dut.instr, prog[0]);

        rstn = 1'b0;
        repeat (4) tick();
        check("rf1_addi", dut.U_SCPU.U_RF.rf[1], 32'd5);
        check("rf2_slti_lt", dut.U_SCPU.U_RF.rf[2], 32'd1);
        check("rf3_slti_eq", dut.U_SCPU.U_RF.rf[3], 32'd0);
        check("rf4_slti_neg", dut.U_SCPU.U_RF.rf[4], 32'd0);
        reg_sel = 5'd2;
        #1;
        check("dbg_rf2", reg_data, 32'd1);

        repeat (3) tick();
        check("rf5_addi_neg", dut.U_SCPU.U_RF.rf[5], 32'hFFFF_FFFD);
        check("rf6_slti_signed", dut.U_SCPU.U_RF.rf[6], 32'd1);
        check("rf7_sltiu", dut.U_SCPU.U_RF.rf[7], 32'd0);

        repeat (4) tick();
        check("rf8_lui_ori", dut.U_SCPU.U_RF.rf[8], 32'h1234_5678);
        check("rf9_lw", dut.U_SCPU.U_RF.rf[9], 32'h1234_5678);

        tick();
        check("beq_pc", dut.PC, 32'h34);
        tick();
        check("jal_pc", dut.PC, 32'h48);
        check("jal_ra", dut.U_SCPU.U_RF.rf[31], 32'h38);
        check("skipped_rf10", dut.U_SCPU.U_RF.rf[10], 32'h0);
        tick();
        check("rf0_write", dut.U_SCPU.U_RF.rf[0], 32'h0);
        reg_sel = 5'd0;
        #1;
        check("dbg_rf0", reg_data, 32'h0);
        tick();
        check("rf12_add", dut.U_SCPU.U_RF.rf[12], 32'd2);
        repeat (2) tick();
        check("j_self_pc", dut.PC, 32'h50);

        // ---------------- reset mid-program ----------------
        rstn = 1'b1;
        tick();
        rstn   = 1'b0;
        budget = 0;
        while (dut.PC !== 32'h20 && budget < 40) begin
            tick();
            budget++;
        end
        check("reach_pc20", dut.PC, 32'h20);
        rstn = 1'b1;
        tick();
        check("midrst_pc", dut.PC, 32'h0);
        any_set = 32'h0;
        for (int i = 0; i < 32; i++) any_set = any_set | dut.U_SCPU.U_RF.rf[i];
        check("midrst_rf_zero", any_set, 32'h0);
        reg_sel = 5'd1;
        #1;
        check("midrst_reg_data", reg_data, 32'h0);
        check("midrst_instr", dut.instr, prog[0]);
        rstn = 1'b0;
        tick();
        check("resume_pc", dut.PC, 32'h4);
        check("resume_rf1", dut.U_SCPU.U_RF.rf[1], 32'd5);

        // ---------------- random programs vs. model ----------------
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) prog[i] = enc_i(6'h2B, 5'd0, 5'd0, 16'(i * 4));
        for (int i = 8; i < 128; i++) prog[i] = rand_instr();
        load_rom();
        for (int i = 0; i < 128; i++) m_dm[i] = 32'h0;
        model_reset();
        tick();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rstn = (cyc == 200);
            if (rstn) model_reset();
            else      model_step();
            tick();
            reg_sel = 5'($urandom_range(0, 31));
            #1;
            check("rnd_pc", dut.PC, m_pc);
            check("rnd_reg", reg_data, m_rf[reg_sel]);
        end
        for (int i = 1; i < 32; i++)
            check($sformatf("end_rf%0d", i), dut.U_SCPU.U_RF.rf[i], m_rf[i]);
        for (int i = 0; i < 8; i++)
            check($sformatf("end_dm%0d", i), dut.U_DM.ram[i], m_dm[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sccomp.md
# sccomp

Single-cycle MIPS-subset computer: processor core, instruction ROM, data RAM and 32×32 register file behind a minimal top-level port set. Every instruction fetches, decodes, executes and retires in one `clk` cycle. The `reg_sel`/`reg_data` debug port exposes any architectural register combinationally. The block is the top of the simulation and FPGA build; programs are preloaded into the instruction ROM.

## Interface
Parameters:
- `IM_DEPTH`, default 128: instruction ROM words, addressed by `PC[8:2]`.
- `DM_DEPTH`, default 128: data RAM words, addressed by `addr[8:2]`.

Ports:
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rstn` input, 1 bit: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `reg_sel` input, 5 bits: debug register index.
- `reg_data` output, 32 bits: `rf[reg_sel]` combinationally; reads 0 when `reg_sel` is 0.

## Operation
- Required hierarchy, for bench and debug access:
  - `U_SCPU`: core, with register `PC`.
  - `U_SCPU.U_RF`: register file, array `rf[31:0]`.
  - `U_IM`: ROM, array `ROM[0:IM_DEPTH-1]`, loadable by `$readmemh`.
  - `U_DM`: data RAM.
  - Top-level wires `PC` and `instr`.
- `instr = ROM[PC[8:2]]`, combinational.
- Supported instructions:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
  - I-type: addi, addiu, andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne.
  - J-type: j, jal.
- Immediate extension:
  - Sign-extend for addi, addiu, slti, sltiu, lw, sw, beq, bne.
  - Zero-extend for andi, ori, xori.
  - lui writes `{imm,16'h0}`.
- Comparisons:
  - slt/slti compare signed 32-bit.
  - sltu/sltiu compare unsigned, after sign-extension of the immediate.
  - Result is 32'h1 or 32'h0.
- Overflow is not trapped; add/addi wrap mod 2^32.
- Destination register: rd for R-type, rt for I-type, 31 for jal. jal writes PC+4.
- Writes to `rf[0]` are discarded; `rf[0]` always reads 0.
- Next PC:
  - Default is PC+4.
  - Taken beq/bne: PC+4+(sext(imm)<<2).
  - j/jal: `{PC+4[31:28], target, 2'b00}`.
  - jr: `rs`.
- Undefined opcode or funct executes as NOP: no writes, PC+4.
- Memory accesses are word-only; `addr[1:0]` is ignored.
  - lw returns RAM data combinationally.
  - sw writes `rt` on the clock edge.

## Timing
- Reset, on a rising edge with `rstn`=1:
  - PC←0.
  - `rf[1..31]`←0.
  - Data RAM is not cleared.
  - No register or memory write from the current instruction takes effect.
- Output values during reset: `reg_data` is 0 for every `reg_sel`; `instr` = ROM[0].
- First instruction retires on the first rising edge with `rstn`=0.
- Latency is exactly one cycle per instruction. PC, register file and data RAM all update on the same edge.
- Register file: two combinational read ports, one write port.
- A read of a register being written in the same cycle returns the old value.
- PC wraps silently at 2^32. ROM index truncates to `PC[8:2]` (wrap-around within the ROM).
- Reset asserted mid-program aborts the current instruction and restarts at PC 0 on the next edge.
- `reg_data` reflects register writes one edge after they occur.

## Structure
- Shared package `sccomp_pkg` holds:
  - Opcode and funct localparams.
  - ALU-op enum.
  - Next-PC-select enum.
  - Write-back-select enum.
  - Width constants.
- Sub-modules:
  - `sccpu` (instance `U_SCPU`, containing `rf` as `U_RF`, ALU and control).
  - `im` (`U_IM`).
  - `dm` (`U_DM`).
- The control decoder is the one natural separate sub-module inside the core: `ctrl`, purely combinational.

## Test plan
- Reset, then addi $1,$0,5; slti $2,$1,7; slti $3,$1,5; slti $4,$1,-1.
  - Required: rf[1]=5, rf[2]=1, rf[3]=0, rf[4]=0.
  - `reg_sel`=2 gives `reg_data`=1.
- addi $5,$0,-3; slti $6,$5,-2; sltiu $7,$5,1.
  - Required: rf[5]=FFFFFFFD, rf[6]=1, rf[7]=0.
- lui $8,0x1234; ori $8,$8,0x5678; sw $8,4($0); lw $9,4($0).
  - Required: rf[9]=12345678.
- beq taken over one instruction, then jal to word 0x12.
  - Required: skipped instruction has no effect; rf[31]=return address; PC reaches 0x48.
- Program running; assert `rstn` for one edge after PC=0x20.
  - Required: PC=0, rf all 0, execution resumes from ROM[0].
- addi $0,$0,7.
  - Required: rf[0] remains 0; `reg_sel`=0 gives `reg_data`=0.
